// File: rtl/proc_control.sv
// Control FSM for the bus-based add/sub datapath: fetches {op,X,Y} into IR
// and sequences register write enables, bus selects and ALU mode. Optional PROC_CTRL_STEP_EN.
module proc_control #(
   parameter int NREG = 4,
   parameter int SELW = 2
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Run,
`ifdef PROC_CTRL_STEP_EN
   input  logic              Step,
`endif
   input  logic [2*SELW+1:0] DIN,
   output logic              IRWn,
   output logic [NREG-1:0]   RWn,
   output logic              AWn,
   output logic              GWn,
   output logic [NREG-1:0]   Rout,
   output logic              Gout,
   output logic              DINout,
   output logic              AddSub,
   output logic              Done,
   output logic              Busy
);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   localparam int IW = 2*SELW + 2;

   state_t          state;
   logic [IW-1:0]   ir;
   logic [1:0]      op;
   logic [SELW-1:0] x_sel;
   logic [SELW-1:0] y_sel;
   logic [NREG-1:0] x_oh;
   logic [NREG-1:0] y_oh;
   logic            adv;

   assign op    = ir[IW-1 -: 2];
   assign x_sel = ir[2*SELW-1 -: SELW];
   assign y_sel = ir[SELW-1:0];
   assign x_oh  = {{(NREG-1){1'b0}}, 1'b1} << x_sel;
   assign y_oh  = {{(NREG-1){1'b0}}, 1'b1} << y_sel;

`ifdef PROC_CTRL_STEP_EN
   assign adv = Step;
`else
   assign adv = 1'b1;
`endif

   assign Busy = (state != T0);

   // state and IR; IR captured only on a T0 fetch
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state <= T0;
         ir    <= '0;
      end else begin
         unique case (state)
            T0: begin
               if (Run) begin
                  ir    <= DIN;
                  state <= T1;
               end
            end
            T1: if (adv) state <= op[1] ? T2 : T0;
            T2: if (adv) state <= T3;
            T3: if (adv) state <= T0;
            default: state <= T0;
         endcase
      end
   end

   // control outputs decoded from state, IR and (in T0) Run
   always_comb begin
      IRWn   = 1'b1;
      RWn    = '1;
      AWn    = 1'b1;
      GWn    = 1'b1;
      Rout   = '0;
      Gout   = 1'b0;
      DINout = 1'b0;
      AddSub = 1'b0;
      Done   = 1'b0;
      unique case (state)
         T0: begin
            if (Run) begin
               IRWn   = 1'b0;
               DINout = 1'b1;
            end
         end
         T1: begin
            unique case (op)
               2'b00: begin
                  Rout = y_oh;
                  RWn  = ~x_oh;
                  Done = 1'b1;
               end
               2'b01: begin
                  DINout = 1'b1;
                  RWn    = ~x_oh;
                  Done   = 1'b1;
               end
               default: begin
                  Rout = x_oh;
                  AWn  = 1'b0;
               end
            endcase
         end
         T2: begin
            Rout   = y_oh;
            GWn    = 1'b0;
            AddSub = op[0];
         end
         T3: begin
            Gout   = 1'b1;
            RWn    = ~x_oh;
            AddSub = op[0];
            Done   = 1'b1;
         end
         default: ;
      endcase
      // a held step keeps the bus selected but commits nothing
      if (state != T0 && !adv) begin
         RWn  = '1;
         AWn  = 1'b1;
         GWn  = 1'b1;
         Done = 1'b0;
      end
   end

endmodule
